// File: rtl/proc_sequencer.sv
// proc_sequencer: raster-walks the processing buffer once per start and writes ALU results (or a border constant) to the frame buffer.
module proc_sequencer #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int AW_P = 17,
  parameter int AW_F = 17,
  parameter int DW = 12,
  parameter int RD_LAT = 1,
  parameter logic [DW-1:0] BORDER_VAL = '0
) (
  input  logic            sys_clk,
  input  logic            rst,
  input  logic            start,
  input  logic            enable,
  input  logic            stall,
  output logic [AW_P-1:0] raddr_alu,
  input  logic [DW-1:0]   alu_dout,
  output logic [AW_F-1:0] waddr_alu,
  output logic [DW-1:0]   wdata_alu,
  output logic            wen_alu,
  output logic            busy,
  output logic            done
);
  localparam int N = IMG_W * IMG_H;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [AW_P-1:0] idx_q;
  logic [RD_LAT-1:0] vld_q;
  logic [AW_P-1:0] pidx_q [RD_LAT];
  logic brd_q [RD_LAT];
  logic [AW_F-1:0] waddr_q;
  logic [DW-1:0] wdata_q;
  logic issue, last, x_last, border;
  assign issue = state_q == RUN && !stall;
  assign last = idx_q == AW_P'(N - 1);
  assign x_last = x_q == XW'(IMG_W - 1);
  assign border = x_q == '0 || x_last || y_q == '0 || y_q == YW'(IMG_H - 1);
  // idx_q doubles as the presented read address; it stops at N-1 so no out-of-range address is shown
  assign raddr_alu = idx_q;
  assign wen_alu = vld_q[RD_LAT-1];
  assign waddr_alu = wen_alu ? AW_F'(pidx_q[RD_LAT-1]) : waddr_q;
  assign wdata_alu = wen_alu ? (brd_q[RD_LAT-1] ? BORDER_VAL : alu_dout) : wdata_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      idx_q <= '0;
      vld_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      waddr_q <= waddr_alu;
      wdata_q <= wdata_alu;
      vld_q <= (vld_q << 1) | RD_LAT'(issue);
      pidx_q[0] <= idx_q;
      brd_q[0] <= border;
      for (int i = 1; i < RD_LAT; i++) begin
        pidx_q[i] <= pidx_q[i-1];
        brd_q[i] <= brd_q[i-1];
      end
      case (state_q)
        IDLE: if (start && enable) begin
          state_q <= RUN;
          x_q <= '0;
          y_q <= '0;
          idx_q <= '0;
        end
        RUN: if (issue) begin
          if (last) state_q <= DRAIN;
          else begin
            idx_q <= idx_q + 1'b1;
            x_q <= x_last ? '0 : x_q + 1'b1;
            y_q <= x_last ? y_q + 1'b1 : y_q;
          end
        end
        // done must follow the final write directly, so look only at entries still queued behind the output stage
        DRAIN: if ((vld_q << 1) == '0) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
